traffic_signal_controller_param: RTL

//  Parametrised next generation of the highway/country-road traffic signal controller.

---
 rtl/traffic_signal_controller_param_pkg.sv | 42 ++++
 rtl/traffic_signal_controller_param_phase_timer.sv | 34 +++
 rtl/traffic_signal_controller_param.sv | 127 ++++++++++++
 3 files changed

// File: rtl/traffic_signal_controller_param_pkg.sv
// Shared types and light decode for the parametrised traffic signal controller.
package traffic_signal_controller_param_pkg;

   // Phase codes double as the debug phase output.
   typedef enum logic [2:0] {
      StHg = 3'd0,
      StHy = 3'd1,
      StAr = 3'd2,
      StCg = 3'd3,
      StCy = 3'd4,
      StFl = 3'd5
   } state_e;

   typedef logic [1:0] light_t;

   localparam light_t LightRed    = 2'd0;
   localparam light_t LightYellow = 2'd1;
   localparam light_t LightGreen  = 2'd2;
   localparam light_t LightOff    = 2'd3;

   typedef struct packed {
      light_t hwy;
      light_t country;
   } lights_t;

   // Light pair shown for a registered state; unknown codes show the reset pair.
   function automatic lights_t decode_lights(state_e st, logic blink);
      lights_t l;
      case (st)
         StHg:    l = '{hwy: LightGreen,  country: LightRed};
         StHy:    l = '{hwy: LightYellow, country: LightRed};
         StAr:    l = '{hwy: LightRed,    country: LightRed};
         StCg:    l = '{hwy: LightRed,    country: LightGreen};
         StCy:    l = '{hwy: LightRed,    country: LightYellow};
         StFl:    l = blink ? '{hwy: LightOff,    country: LightOff}
                            : '{hwy: LightYellow, country: LightRed};
         default: l = '{hwy: LightGreen,  country: LightRed};
      endcase
      return l;
   endfunction

endpackage

// File: rtl/traffic_signal_controller_param_phase_timer.sv
// Saturating phase timer: counts cycles spent in the current phase.
module traffic_signal_controller_param_phase_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear wins; otherwise count up and hold at all-ones so long phases never wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/traffic_signal_controller_param.sv
// Highway / country-road signal controller with programmable timing and night flash.
module traffic_signal_controller_param
   import traffic_signal_controller_param_pkg::*;
#(
   parameter int unsigned CNT_W          = 8,
   parameter int unsigned HWY_MIN_GREEN  = 8,
   parameter int unsigned Y2R_CYCLES     = 3,
   parameter int unsigned R2G_CYCLES     = 2,
   parameter int unsigned CTRY_MAX_GREEN = 10,
   parameter int unsigned FLASH_HALF     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       x,
   input  logic       flash_mode,
   output logic [1:0] hwy,
   output logic [1:0] country,
   output logic [2:0] phase
);

   // Last timer value of each timed phase.
   localparam logic [CNT_W-1:0] HwyLast   = CNT_W'(HWY_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] Y2rLast   = CNT_W'(Y2R_CYCLES - 1);
   localparam logic [CNT_W-1:0] R2gLast   = CNT_W'(R2G_CYCLES - 1);
   localparam logic [CNT_W-1:0] CtryLast  = CNT_W'(CTRY_MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] FlashLast = CNT_W'(FLASH_HALF - 1);

   state_e           state_q, state_d;
   logic             blink_q, blink_d;
   logic             ret_hg_q, ret_hg_d;
   logic             tmr_clr;
   logic [CNT_W-1:0] tmr;
   lights_t          lights;

   traffic_signal_controller_param_phase_timer #(
      .CNT_W (CNT_W)
   ) u_phase_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (tmr_clr),
      .cnt   (tmr)
   );

   // State, blink phase and return-to-highway flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StHg;
         blink_q  <= 1'b0;
         ret_hg_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         blink_q  <= blink_d;
         ret_hg_q <= ret_hg_d;
      end
   end

   // Next-state logic; the timer restarts on every transition and each flash half-period.
   always_comb begin
      state_d  = state_q;
      blink_d  = blink_q;
      ret_hg_d = ret_hg_q;
      tmr_clr  = 1'b0;
      case (state_q)
         StHg: begin
            // Flash requests bypass the highway minimum green.
            if (flash_mode || (x && (tmr >= HwyLast))) begin
               state_d = StHy;
            end
         end
         StHy: begin
            if (tmr == Y2rLast) begin
               state_d = flash_mode ? StFl : StAr;
            end
         end
         StAr: begin
            if (tmr == R2gLast) begin
               if (ret_hg_q) begin
                  state_d  = StHg;
                  ret_hg_d = 1'b0;
               end else begin
                  state_d = StCg;
               end
            end
         end
         StCg: begin
            if (!x || flash_mode || (tmr == CtryLast)) begin
               state_d = StCy;
            end
         end
         StCy: begin
            if (tmr == Y2rLast) begin
               state_d = flash_mode ? StFl : StHg;
            end
         end
         StFl: begin
            if (tmr == FlashLast) begin
               tmr_clr = 1'b1;
               if (!flash_mode) begin
                  // Leaving flash clears the junction, then hands back to the highway.
                  state_d  = StAr;
                  ret_hg_d = 1'b1;
                  blink_d  = 1'b0;
               end else begin
                  blink_d = ~blink_q;
               end
            end
         end
         default: begin
            state_d  = StHg;
            blink_d  = 1'b0;
            ret_hg_d = 1'b0;
         end
      endcase
      if (state_d != state_q) begin
         tmr_clr = 1'b1;
      end
   end

   // Moore outputs decoded from registered state only.
   always_comb begin
      lights  = decode_lights(state_q, blink_q);
      hwy     = lights.hwy;
      country = lights.country;
      phase   = state_q;
   end

endmodule
